// File: rtl/mac_pkg.sv
// Shared state encoding and default sizing for the mac_array slice.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_LANES      = 2;

endpackage

// File: rtl/mac_fifo.sv
// Show-ahead FIFO storage with private pointers; fill level is tracked by the parent.
module mac_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mac_array.sv
// Multi-lane FIFO-fed multiply-accumulate array with a shared IDLE/EXEC/DONE controller.
// Define MAC_SATURATE_EN to clamp accumulation instead of wrapping.
module mac_array
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LANES      = DEF_LANES,
  parameter int ACC_W      = 2 * DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [LANES*DATA_WIDTH-1:0] a_in,
  input  logic [LANES*DATA_WIDTH-1:0] b_in,
  input  logic                        start,
  output logic                        full,
  output logic                        empty,
  output logic                        done,
  output logic [1:0]                  state,
  output logic [LANES*ACC_W-1:0]      result
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = 2 * DATA_WIDTH;

  state_t        state_q, state_d;
  logic [CW-1:0] count;
  logic          push, pop, fire;

  assign push  = wr_en && !full && (state_q != EXEC);
  assign pop   = (state_q == EXEC);
  assign fire  = start && (state_q != EXEC) && ((count != '0) || push);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign done  = (state_q == DONE);
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire) state_d = EXEC;
      EXEC:    if (count == CW'(1)) state_d = DONE;
      DONE: begin
        if (fire)      state_d = EXEC;
        else if (push) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Push and pop are mutually exclusive: writes are refused during EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (push) count <= count + CW'(1);
    else if (pop)  count <= count - CW'(1);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic        [DATA_WIDTH-1:0] a_rd, b_rd;
    logic signed [PW-1:0]         a_x, b_x, prod;
    logic signed [ACC_W-1:0]      prod_ext, acc, acc_nxt;

    mac_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
      .wr_data(a_in[l*DATA_WIDTH +: DATA_WIDTH]), .rd_data(a_rd)
    );

    mac_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
      .wr_data(b_in[l*DATA_WIDTH +: DATA_WIDTH]), .rd_data(b_rd)
    );

    assign a_x      = PW'($signed(a_rd));
    assign b_x      = PW'($signed(b_rd));
    assign prod     = a_x * b_x;
    assign prod_ext = ACC_W'(prod);

`ifdef MAC_SATURATE_EN
    logic signed [ACC_W:0] sum;
    assign sum = $signed({acc[ACC_W-1], acc}) + $signed({prod_ext[ACC_W-1], prod_ext});
    // Top two sum bits disagree only when the ACC_W-bit result overflowed.
    always_comb begin
      acc_nxt = sum[ACC_W-1:0];
      if (sum[ACC_W] != sum[ACC_W-1])
        acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign acc_nxt = acc + prod_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    acc <= '0;
      else if (fire) acc <= '0;
      else if (pop)  acc <= acc_nxt;
    end

    assign result[l*ACC_W +: ACC_W] = acc;
  end

endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array (8-bit operands, depth 8, 2 lanes, 16-bit accumulators).
module tb_mac_array;

  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int LN  = 2;
  localparam int AW  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [LN*DW-1:0] a_in, b_in;
  logic            start;
  logic            full, empty, done;
  logic [1:0]      state;
  logic [LN*AW-1:0] result;

  mac_array #(.DATA_WIDTH(DW), .DEPTH(DEP), .LANES(LN), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .a_in(a_in), .b_in(b_in),
    .start(start), .full(full), .empty(empty), .done(done),
    .state(state), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct { int a0; int b0; int a1; int b1; } ent_t;

  ent_t        q[$];
  int          mstate;
  logic [15:0] exp_res [2];
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference accumulate step: exact integer sum, then wrap or clamp to 16 bits.
  function automatic int acc_step(input int acc, input int p);
    int          s;
    logic [15:0] t;
    s = acc + p;
`ifdef MAC_SATURATE_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
`else
    t = s[15:0];
    return int'($signed(t));
`endif
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic chk_res(input string tag);
    chk({tag, "_lane0"}, {48'd0, result[15:0]},  {48'd0, exp_res[0]});
    chk({tag, "_lane1"}, {48'd0, result[31:16]}, {48'd0, exp_res[1]});
  endtask

  task automatic drive(input int a0, input int b0, input int a1, input int b1);
    logic [31:0] v;
    v = a0; a_in[7:0]  = v[7:0];
    v = a1; a_in[15:8] = v[7:0];
    v = b0; b_in[7:0]  = v[7:0];
    v = b1; b_in[15:8] = v[7:0];
  endtask

  task automatic write(input int a0, input int b0, input int a1, input int b1);
    ent_t e;
    e = '{a0, b0, a1, b1};
    drive(a0, b0, a1, b1);
    wr_en = 1'b1;
    if (q.size() < DEP) begin
      q.push_back(e);
      if (mstate == 2) mstate = 0;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("wr_state", {62'd0, state}, 64'(mstate));
    chk("wr_full", {63'd0, full}, {63'd0, q.size() == DEP});
    chk("wr_empty", {63'd0, empty}, {63'd0, q.size() == 0});
  endtask

  // Issue start (optionally with a same-cycle write), then follow the whole EXEC phase.
  task automatic run(input bit with_wr, input ent_t e, input bit junk);
    int n, acc0, acc1;
    ent_t x;
    if (with_wr) begin
      drive(e.a0, e.b0, e.a1, e.b1);
      wr_en = 1'b1;
      if (q.size() < DEP) q.push_back(e);
    end
    n = q.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    if (n == 0) begin
      chk("idle_start_state", {62'd0, state}, 64'(mstate));
      chk("idle_start_empty", {63'd0, empty}, 64'd1);
      return;
    end
    chk("exec_enter", {62'd0, state}, 64'd1);
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < n; i++) begin
      x = q.pop_front();
      acc0 = acc_step(acc0, x.a0 * x.b0);
      acc1 = acc_step(acc1, x.a1 * x.b1);
      if (junk) begin
        drive(100, 100, 100, 100);
        wr_en = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      start = 1'b0;
      if (i < n - 1) chk("exec_hold", {62'd0, state}, 64'd1);
    end
    exp_res[0] = acc0[15:0];
    exp_res[1] = acc1[15:0];
    mstate = 2;
    chk("done_state", {62'd0, state}, 64'd2);
    chk("done_flag", {63'd0, done}, 64'd1);
    chk("done_empty", {63'd0, empty}, 64'd1);
    chk("done_full", {63'd0, full}, 64'd0);
    chk_res("done_res");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ent_t e;
    int   n;
    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    mstate = 0; exp_res[0] = '0; exp_res[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk_res("rst_res");

    // Basic accumulation: lane0 = 2*(1+2+3+4) = 20, lane1 = 4*(-3) = -12.
    for (int i = 1; i <= 4; i++) write(i, 2, -1, 3);
    e = '{0, 0, 0, 0};
    run(1'b0, e, 1'b0);
    chk("basic_l0_const", {48'd0, result[15:0]}, 64'd20);
    chk("basic_l1_const", {48'd0, result[31:16]}, {48'd0, 16'hFFF4});

    // Fill to DEPTH; first write leaves DONE while result holds.
    write(rnd8(), rnd8(), rnd8(), rnd8());
    chk_res("done_to_idle_hold");
    for (int i = 1; i < DEP; i++) write(rnd8(), rnd8(), rnd8(), rnd8());
    chk("full_set", {63'd0, full}, 64'd1);
    write(100, 1, 100, 1);
    run(1'b0, e, 1'b0);

    // Overflow: 8 * 127*127.
    for (int i = 0; i < DEP; i++) write(127, 127, 127, 127);
    run(1'b0, e, 1'b0);
`ifdef MAC_SATURATE_EN
    chk("ovf_const", {48'd0, result[15:0]}, 64'd32767);
`else
    chk("ovf_const", {48'd0, result[15:0]}, {48'd0, 16'hF808});
`endif

    // Asynchronous reset during the second EXEC cycle.
    for (int i = 0; i < 3; i++) write(rnd8(), rnd8(), rnd8(), rnd8());
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {62'd0, state}, 64'd0);
    chk("midrst_empty", {63'd0, empty}, 64'd1);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_res", {32'd0, result}, 64'd0);
    q.delete(); mstate = 0; exp_res[0] = '0; exp_res[1] = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run(1'b0, e, 1'b0);
    chk_res("post_rst_res");

    // Same-cycle write and start with nothing stored: one EXEC cycle.
    e = '{rnd8(), rnd8(), rnd8(), rnd8()};
    run(1'b1, e, 1'b0);

    // Randomized rounds, with dropped writes/starts during EXEC.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, DEP + 2);
      for (int i = 0; i < n; i++) write(rnd8(), rnd8(), rnd8(), rnd8());
      e = '{rnd8(), rnd8(), rnd8(), rnd8()};
      run(1'($urandom_range(0, 1)), e, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mac_array.md
MAC_ARRAY -- requirements
Module: mac_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed operand width per lane.
REQ-002 SHALL have parameter DEPTH, default 8, entries per lane FIFO (power of two, >=2).
REQ-003 SHALL have parameter LANES, default 2, number of independent MAC channels.
REQ-004 SHALL have parameter ACC_W, default 2*DATA_WIDTH, signed accumulator width per lane.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, push one operand vector into all lane FIFOs.
REQ-008 SHALL have port a_in, input, LANES*DATA_WIDTH, lane i A operand at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port b_in, input, LANES*DATA_WIDTH, lane i B operand, packed the same way.
REQ-010 SHALL have port start, input, 1, single-cycle request to run the accumulation.
REQ-011 SHALL have port full, output, 1, FIFOs hold DEPTH entries.
REQ-012 SHALL have port empty, output, 1, FIFOs hold 0 entries.
REQ-013 SHALL have port done, output, 1, high while in DONE.
REQ-014 SHALL have port state, output, 2, encoding IDLE=00, EXEC=01, DONE=10.
REQ-015 SHALL have port result, output, LANES*ACC_W, lane i accumulator at bits [i*ACC_W +: ACC_W].

Function
REQ-016 SHALL accept wr_en only in IDLE or DONE with full=0; a write while full or in EXEC is dropped with no state change.
REQ-017 SHALL move from DONE to IDLE on the first accepted write; result holds its value.
REQ-018 SHALL, on start in IDLE or DONE with at least one entry after any same-cycle write, clear all accumulators and enter EXEC next cycle.
REQ-019 SHALL ignore start when the FIFO count, including a same-cycle write, is 0.
REQ-020 SHALL, in EXEC, pop one entry per lane per cycle and add the full-width signed product a*b, sign-extended to ACC_W, into that lane's accumulator in the same clock edge.
REQ-021 SHALL enter DONE on the edge that pops the last entry, so N entries take exactly N EXEC cycles.
REQ-022 SHALL hold all lanes in lockstep, with one shared count, full and empty.
REQ-023 SHALL ignore start during EXEC.
REQ-024 SHALL wrap FIFO read and write pointers modulo DEPTH, with count 0..DEPTH kept separately.
REQ-025 SHALL wrap accumulator overflow two's-complement modulo 2^ACC_W unless MAC_SATURATE_EN is defined.

Reset
REQ-026 SHALL, while rst_n=0 and at any time including mid-EXEC, force state=IDLE, all pointers and the count to 0, empty=1, full=0, done=0, result=0.
REQ-027 SHALL discard FIFO contents on reset; storage data is don't-care.

Configuration
REQ-028 SHALL, with MAC_SATURATE_EN defined, clamp each accumulate step to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; without the macro, the sum wraps.

Structure
REQ-029 SHALL place the state enum (IDLE/EXEC/DONE) and the default parameter constants in package mac_pkg.
REQ-030 SHALL instantiate one sub-module, mac_fifo: a parametrised show-ahead FIFO, one instance per lane per operand, with the count logic shared at the top level.

Verification (DATA_WIDTH=8, DEPTH=8, LANES=2, ACC_W=16)
REQ-031 SHALL cover reset: after rst_n pulse -> state=00, empty=1, full=0, done=0, result=0.
REQ-032 SHALL cover basic accumulation: 4 writes with lane0 a=1,2,3,4, b=2 and lane1 a=-1, b=3, then start -> state=01 for 4 cycles, then state=10, done=1, lane0=20, lane1=-12.
REQ-033 SHALL cover the full boundary: 8 writes -> full=1; a 9th write of a=100 is dropped; after start, the result excludes 100 and empty=1 at DONE.
REQ-034 SHALL cover overflow: 8 writes of a=127, b=127 -> lane=-2040 (wrap); with MAC_SATURATE_EN -> lane=32767.
REQ-035 SHALL cover reset mid-op: rst_n=0 on the 2nd EXEC cycle -> state=00 immediately, empty=1, result=0; a later start is ignored.
REQ-036 SHALL cover simultaneous events: start alone with empty=1 -> state stays 00; wr_en and start together in IDLE with 0 entries -> EXEC of 1 cycle, lane=a*b.
